// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the 8-bit timer APB register front-end.
// Register offsets, TCR/STATUS bit positions, the APB slave FSM state type
// and the writable-bit mask of TCR. The mask depends on the TIMER_IRQ_EN
// macro: when it is defined, the two interrupt-enable bits of TCR are
// writable; otherwise they read as 0.
package timer_pkg;

    // Register offsets, decoded from PADDR[1:0]
    localparam logic [1:0] OFF_TDR    = 2'd0;
    localparam logic [1:0] OFF_TCR    = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_TCNT   = 2'd3;

    // TCR bit positions
    localparam int TCR_LOAD    = 7;
    localparam int TCR_UPDN    = 5;
    localparam int TCR_EN      = 4;
    localparam int TCR_UDF_IE  = 3;
    localparam int TCR_OVF_IE  = 2;
    localparam int TCR_CKS_MSB = 1;
    localparam int TCR_CKS_LSB = 0;

    // STATUS bit positions (also the matching TSR pulse bits)
    localparam int ST_OVF = 0;
    localparam int ST_UDF = 1;

    // Width of the free-running prescale counter (divide by up to 16)
    localparam int PRESCALE_W = 4;

    // Bits of TCR that hold state. Load (bit 7) is a pulse, not state.
`ifdef TIMER_IRQ_EN
    localparam logic [7:0] TCR_RW_MASK = 8'h3F;
`else
    localparam logic [7:0] TCR_RW_MASK = 8'h33;
`endif

    // APB slave transfer tracking
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: gated count-clock generator for the timer counter.
// A free-running counter advances every PCLK while enabled; the selected
// counter bit is registered onto clk_in, so CKS=0..3 divides PCLK by
// 2/4/8/16. Disabling clears the counter and forces clk_in low on the next
// edge. Because clk_in always comes from a flop, a CKS change while
// running can shorten one period but cannot produce a glitch.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       en,
    input  logic [1:0] cks,
    output logic       clk_in
);

    logic [PRESCALE_W-1:0] cnt_reg;
    logic                  clk_in_reg;

    // Divider counter and registered tap selection
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_reg    <= '0;
            clk_in_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg    <= '0;
            clk_in_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_reg + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            clk_in_reg <= cnt_reg[cks];
        end
    end

    assign clk_in = clk_in_reg;

endmodule

// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB3 slave register block for the 8-bit timer.
// Owns TDR, TCR (with self-clearing Load), the sticky OVF/UDF status flags
// and a read-only view of the counter value. Drives the counter's TCR, TDR
// and prescaled clk_in, and captures its one-cycle TSR flag pulses.
// Optional feature macro: TIMER_IRQ_EN adds the OVF/UDF interrupt enables
// in TCR[2]/TCR[3] and a registered irq output; without it irq is tied low.
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [7:0]        PWDATA,
    output logic [7:0]        PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        TCR,
    output logic [7:0]        TDR,
    input  logic [7:0]        TCNT,
    input  logic [7:0]        TSR,
    output logic              clk_in,
    output logic              irq
);

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

    // ------------------------------------------------------------------
    // APB transfer tracking
    // ------------------------------------------------------------------
    apb_state_e state_reg;
    logic [3:0] wait_cnt_reg;
    logic       in_xfer;
    logic       access_cycle;
    logic       wait_done;

    // A transfer is only honoured after its setup phase has been seen, so
    // PENABLE arriving without a preceding setup never completes.
    assign in_xfer      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign access_cycle = PSEL && PENABLE && in_xfer;
    assign wait_done    = (wait_cnt_reg == WAIT_LIMIT);
    assign PREADY       = access_cycle && wait_done;

    // Setup/access sequencing with a wait-state counter; a dropped PSEL
    // abandons the transfer without touching any register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= 4'd0;
                    if (PSEL && !PENABLE) begin
                        state_reg <= SETUP;
                    end
                end
                SETUP, ACCESS: begin
                    if (!PSEL) begin
                        state_reg    <= IDLE;
                        wait_cnt_reg <= 4'd0;
                    end else if (PENABLE) begin
                        if (wait_done) begin
                            // Completing cycle; a following setup phase is
                            // picked up from IDLE on the next edge.
                            state_reg    <= IDLE;
                            wait_cnt_reg <= 4'd0;
                        end else begin
                            state_reg    <= ACCESS;
                            wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    wait_cnt_reg <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address decode and error response
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       addr_err;
    logic       ro_err;
    logic       xfer_err;
    logic       wr_commit;
    logic       rd_commit;
    logic       wr_tdr;
    logic       wr_tcr;
    logic       wr_status;

    assign offset = PADDR[1:0];

    generate
        if (ADDR_W > 2) begin : g_addr_hi
            assign addr_err = |PADDR[ADDR_W-1:2];
        end else begin : g_addr_narrow
            assign addr_err = 1'b0;
        end
    endgenerate

    assign ro_err    = PWRITE && (offset == OFF_TCNT);
    assign xfer_err  = addr_err || ro_err;
    assign PSLVERR   = PREADY && xfer_err;
    assign wr_commit = PREADY && PWRITE && !xfer_err;
    assign rd_commit = PREADY && !PWRITE && !xfer_err;

    assign wr_tdr    = wr_commit && (offset == OFF_TDR);
    assign wr_tcr    = wr_commit && (offset == OFF_TCR);
    assign wr_status = wr_commit && (offset == OFF_STATUS);

    // ------------------------------------------------------------------
    // TDR / TCR
    // ------------------------------------------------------------------
    logic [7:0] tdr_reg;
    logic [6:0] tcr_reg;
    logic       load_reg;

    // Reload value
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tdr_reg <= 8'h00;
        end else if (wr_tdr) begin
            tdr_reg <= PWDATA;
        end
    end

    // Control bits; reserved bits are masked off so they always read 0.
    // Load is a one-PCLK pulse following the write edge, so the counter
    // sees it together with whatever TDR was committed before it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tcr_reg  <= 7'd0;
            load_reg <= 1'b0;
        end else begin
            load_reg <= wr_tcr && PWDATA[TCR_LOAD];
            if (wr_tcr) begin
                tcr_reg <= PWDATA[6:0] & TCR_RW_MASK[6:0];
            end
        end
    end

    assign TDR = tdr_reg;
    assign TCR = {load_reg, tcr_reg};

    // ------------------------------------------------------------------
    // Sticky status flags (W1C, a coincident set wins over the clear)
    // ------------------------------------------------------------------
    logic ovf_reg;
    logic udf_reg;
    logic unused_tsr;

    assign unused_tsr = ^TSR[7:2];

    // Capture counter flag pulses and apply write-one-to-clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
        end else begin
            ovf_reg <= TSR[ST_OVF] || (ovf_reg && !(wr_status && PWDATA[ST_OVF]));
            udf_reg <= TSR[ST_UDF] || (udf_reg && !(wr_status && PWDATA[ST_UDF]));
        end
    end

    // ------------------------------------------------------------------
    // Read data: only driven in a completing, error-free read cycle
    // ------------------------------------------------------------------
    logic [7:0] rdata;

    // Register read mux; STATUS returns the pre-edge flag values
    always_comb begin
        rdata = 8'h00;
        case (offset)
            OFF_TDR:    rdata = tdr_reg;
            OFF_TCR:    rdata = {1'b0, tcr_reg};
            OFF_STATUS: begin
                rdata[ST_OVF] = ovf_reg;
                rdata[ST_UDF] = udf_reg;
            end
            default:    rdata = TCNT;
        endcase
    end

    assign PRDATA = rd_commit ? rdata : 8'h00;

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef TIMER_IRQ_EN
    logic irq_reg;

    // Level interrupt held while an enabled flag is pending
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (ovf_reg && tcr_reg[TCR_OVF_IE]) ||
                       (udf_reg && tcr_reg[TCR_UDF_IE]);
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Count clock generation
    // ------------------------------------------------------------------
    timer_prescaler u_prescaler (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (tcr_reg[TCR_EN]),
        .cks     (tcr_reg[TCR_CKS_MSB:TCR_CKS_LSB]),
        .clk_in  (clk_in)
    );

endmodule
